branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the five-stage core. At fetch it looks up the current PC and produces a taken/not-taken decision plus a target address. These feed the branch-select input and jump-address input of the next-PC selector. At execute it receives the resolved outcome of each branch and updates its branch target buffer (BTB) and 2-bit saturating counters. It also keeps update and mispredict statistics for the performance registers.

## Interface
- ENTRIES, 16, number of BTB entries; power of two, 4..64; IDX = log2(ENTRIES)
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- fetch_pc  input  32  PC of the instruction being fetched
- pred_taken  output  1  predicted taken for fetch_pc; combinational from registered state
- pred_target  output  32  predicted target; 32'h0 when pred_taken=0
- upd_valid  input  1  execute stage resolved a branch/jump this cycle
- upd_pc  input  32  PC of the resolved instruction
- upd_taken  input  1  actual outcome
- upd_target  input  32  actual target (meaningful when upd_taken=1)
- upd_pred_taken  input  1  pred_taken value carried down the pipeline with the instruction
- upd_pred_target  input  32  pred_target value carried down the pipeline with the instruction
- mispredict  output  1  registered; high the cycle after an update whose prediction was wrong
- stat_updates  output  16  count of accepted updates, wraps
- stat_mispred  output  16  count of mispredictions, wraps

## Operation
- Per entry: valid (1), tag (32-IDX-2), target (32), ctr (2).
- Index is pc[IDX+1:2]. Tag is pc[31:IDX+2]. PC bits [1:0] are ignored.
- Lookup hit: valid && tag == fetch_pc tag.
- pred_taken = hit && ctr[1].
- pred_target = entry target when pred_taken, else 0.
- Update, when upd_valid=1; "entry" means the entry at the upd_pc index:
  - Hit, upd_taken=1: ctr saturates up (11 stays 11); target <= upd_target.
  - Hit, upd_taken=0: ctr saturates down (00 stays 00); target unchanged.
  - Miss, upd_taken=1: allocate. valid<=1, tag<=upd_pc tag, target<=upd_target, ctr<=2'b10. Replaces any previous occupant.
  - Miss, upd_taken=0: no BTB change.
- Mispredict condition, evaluated only when upd_valid=1:
  - upd_taken != upd_pred_taken, or
  - upd_taken && upd_pred_taken && upd_target != upd_pred_target.
- Counters:
  - stat_updates increments on every upd_valid.
  - stat_mispred increments on every mispredict.
  - Both are 16-bit modulo; FFFF+1 = 0000.

## Timing
- Lookup is zero-latency combinational from the registers. It is not a path from the upd_* inputs.
- Update takes effect at the rising edge. It is visible to lookups from the next cycle.
- Simultaneous lookup and update to the same index: the lookup returns pre-update state (read-before-write). There is no bypass.
- mispredict is registered: asserted for exactly one cycle, the cycle after the triggering update. Consecutive mispredicting updates hold it high on consecutive cycles.
- stat_* counters update at the same edge as the BTB.
- Reset values:
  - All valid=0, ctr=2'b01, tag=0, target=0.
  - pred_taken=0, pred_target=0.
  - mispredict=0, stat_updates=0, stat_mispred=0.
- rst has priority over upd_valid in the same cycle: the update is dropped and not counted.
- Reset asserted mid-operation clears all state in one cycle. No handshake; upd_valid is a single-cycle pulse per branch and is never stalled by this block.

## Test plan
- After reset, fetch_pc=0x00400010 -> pred_taken=0, pred_target=0, stat_*=0.
- Update with upd_pc=0x00400010, taken, target 0x00400100, pred_taken=0. Next cycle:
  - mispredict=1, stat_mispred=1, stat_updates=1.
  - Lookup of 0x00400010 gives pred_taken=1, pred_target=0x00400100 (ctr=10).
- Counter saturation: from ctr=10, apply three taken updates and then one not-taken (ctr=10, prediction still taken). A second not-taken gives ctr=01 -> pred_taken=0.
- Aliasing (ENTRIES=16): allocate 0x00400010, then allocate 0x00400050 (same index, new tag) -> lookup 0x00400010 gives pred_taken=0; 0x00400050 hits.
- Same-cycle lookup and update, both to 0x00400010 with the entry empty: pred_taken=0 that cycle, 1 the next cycle.
- Counter wrap and reset priority:
  - Preload stat_updates to 0xFFFF via 0xFFFF updates, then one more -> 0x0000.
  - Assert rst together with upd_valid -> no count, all outputs at reset values.

Source files
------------

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for the five-stage core. It combines a
// direct-mapped branch target buffer (BTB) with a 2-bit saturating counter
// per entry.
//
// At fetch, the current PC is looked up combinationally from registered
// state. The lookup produces a taken/not-taken decision and a target address.
// At execute, the resolved outcome of each branch trains the BTB entry
// selected by that branch's PC. The same update also drives a registered
// mispredict pulse and two wrapping statistics counters.
//
// Parameters:
//   ENTRIES          number of BTB entries (power of two, 4..64)
//
// Ports:
//   clk              system clock, all state changes on the rising edge
//   rst              synchronous active-high reset, wins over any update
//   fetch_pc         PC being fetched (lookup address)
//   pred_taken       predicted taken for fetch_pc
//   pred_target      predicted target, zero when pred_taken is low
//   upd_valid        execute stage resolved a branch/jump this cycle
//   upd_pc           PC of the resolved instruction
//   upd_taken        actual outcome
//   upd_target       actual target (meaningful when upd_taken is high)
//   upd_pred_taken   prediction that travelled down with the instruction
//   upd_pred_target  predicted target that travelled down with it
//   mispredict       one-cycle pulse the cycle after a wrong prediction
//   stat_updates     wrapping count of accepted updates
//   stat_mispred     wrapping count of mispredictions
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [15:0] stat_updates,
  output logic [15:0] stat_mispred
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 32 - IDX - 2;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  // BTB storage
  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  // Status registers
  logic        mispredict_q;
  logic        mispredict_d;
  logic [15:0] stat_updates_q;
  logic [15:0] stat_mispred_q;

  // Address decomposition
  logic [IDX-1:0]  f_idx_s;
  logic [TAGW-1:0] f_tag_s;
  logic [IDX-1:0]  u_idx_s;
  logic [TAGW-1:0] u_tag_s;

  // Lookup results
  logic f_hit_s;
  logic u_hit_s;

  // Next value of the entry addressed by upd_pc
  logic            entry_we_s;
  logic [TAGW-1:0] entry_tag_d;
  logic [31:0]     entry_target_d;
  logic [1:0]      entry_ctr_d;

  // Word-alignment bits of both PCs play no part in the lookup or the update.
  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign f_idx_s = fetch_pc[IDX+1:2];
  assign f_tag_s = fetch_pc[31:IDX+2];
  assign u_idx_s = upd_pc[IDX+1:2];
  assign u_tag_s = upd_pc[31:IDX+2];

  // Fetch-side lookup. It reads only registered BTB state, so a same-cycle
  // update to the same index is not visible here (read-before-write).
  always_comb begin
    f_hit_s     = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
    pred_taken  = f_hit_s && ctr_q[f_idx_s][1];
    if (pred_taken) begin
      pred_target = target_q[f_idx_s];
    end else begin
      pred_target = 32'h0000_0000;
    end
  end

  // Execute-side training. Compute the next contents of the addressed entry.
  always_comb begin
    u_hit_s        = valid_q[u_idx_s] && (tag_q[u_idx_s] == u_tag_s);
    entry_we_s     = 1'b0;
    entry_tag_d    = tag_q[u_idx_s];
    entry_target_d = target_q[u_idx_s];
    entry_ctr_d    = ctr_q[u_idx_s];
    if (upd_valid) begin
      if (u_hit_s) begin
        entry_we_s = 1'b1;
        if (upd_taken) begin
          entry_target_d = upd_target;
          if (ctr_q[u_idx_s] == CTR_STRONG_T) begin
            entry_ctr_d = CTR_STRONG_T;
          end else begin
            entry_ctr_d = ctr_q[u_idx_s] + 2'd1;
          end
        end else begin
          if (ctr_q[u_idx_s] == CTR_STRONG_NT) begin
            entry_ctr_d = CTR_STRONG_NT;
          end else begin
            entry_ctr_d = ctr_q[u_idx_s] - 2'd1;
          end
        end
      end else if (upd_taken) begin
        // A taken miss evicts whatever occupied the slot. It starts weakly
        // taken, so the next fetch of this PC predicts taken.
        entry_we_s     = 1'b1;
        entry_tag_d    = u_tag_s;
        entry_target_d = upd_target;
        entry_ctr_d    = CTR_WEAK_T;
      end else begin
        // A not-taken miss is not worth a BTB slot.
        entry_we_s = 1'b0;
      end
    end else begin
      entry_we_s = 1'b0;
    end
  end

  // Mispredict detection. A target mismatch only matters when both the
  // prediction and the outcome were taken.
  always_comb begin
    if (upd_valid) begin
      mispredict_d = (upd_taken != upd_pred_taken) ||
                     (upd_taken && upd_pred_taken &&
                      (upd_target != upd_pred_target));
    end else begin
      mispredict_d = 1'b0;
    end
  end

  // State update for the BTB, the mispredict pulse and the statistics.
  // Reset has priority and also drops any update presented in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0000_0000;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
      mispredict_q   <= 1'b0;
      stat_updates_q <= 16'h0000;
      stat_mispred_q <= 16'h0000;
    end else begin
      if (entry_we_s) begin
        valid_q[u_idx_s]  <= 1'b1;
        tag_q[u_idx_s]    <= entry_tag_d;
        target_q[u_idx_s] <= entry_target_d;
        ctr_q[u_idx_s]    <= entry_ctr_d;
      end
      mispredict_q <= mispredict_d;
      if (upd_valid) begin
        stat_updates_q <= stat_updates_q + 16'd1;
      end
      if (mispredict_d) begin
        stat_mispred_q <= stat_mispred_q + 16'd1;
      end
    end
  end

  assign mispredict   = mispredict_q;
  assign stat_updates = stat_updates_q;
  assign stat_mispred = stat_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int ENTRIES = 16;

  logic        clk;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [15:0] stat_updates;
  logic [15:0] stat_mispred;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .mispredict     (mispredict),
    .stat_updates   (stat_updates),
    .stat_mispred   (stat_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model. Each slot is described by the PC region it belongs to.
  bit          m_valid [ENTRIES];
  longint      m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_upd;
  int          m_mis;
  bit          m_misp;

  function automatic int slot_of(logic [31:0] pc);
    return int'((longint'(pc) / 4) % ENTRIES);
  endfunction

  function automatic longint region_of(logic [31:0] pc);
    return longint'(pc) / (4 * ENTRIES);
  endfunction

  function automatic bit m_pred(logic [31:0] pc);
    int s;
    s = slot_of(pc);
    return m_valid[s] && (m_tag[s] == region_of(pc)) && (m_ctr[s] >= 2);
  endfunction

  function automatic logic [31:0] m_target(logic [31:0] pc);
    logic [31:0] t;
    t = 32'h0;
    if (m_pred(pc)) t = m_tgt[slot_of(pc)];
    return t;
  endfunction

  task automatic model_apply();
    int  s;
    bit  hit;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_tag[i]   = 0;
        m_tgt[i]   = 32'h0;
        m_ctr[i]   = 1;
      end
      m_upd  = 0;
      m_mis  = 0;
      m_misp = 1'b0;
    end else if (upd_valid) begin
      m_upd  = (m_upd + 1) % 65536;
      m_misp = (upd_taken != upd_pred_taken) ||
               (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));
      if (m_misp) m_mis = (m_mis + 1) % 65536;
      s   = slot_of(upd_pc);
      hit = m_valid[s] && (m_tag[s] == region_of(upd_pc));
      if (hit && upd_taken) begin
        m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
        m_tgt[s] = upd_target;
      end else if (hit) begin
        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
      end else if (upd_taken) begin
        m_valid[s] = 1'b1;
        m_tag[s]   = region_of(upd_pc);
        m_tgt[s]   = upd_target;
        m_ctr[s]   = 2;
      end
    end else begin
      m_misp = 1'b0;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: the model consumes the same inputs the DUT samples at the edge.
  task automatic step();
    @(posedge clk);
    model_apply();
    #1;
  endtask

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pred_taken",   {31'd0, pred_taken}, {31'd0, m_pred(fetch_pc)});
      chk("pred_target",  pred_target, m_target(fetch_pc));
      chk("mispredict",   {31'd0, mispredict}, {31'd0, m_misp});
      chk("stat_updates", {16'd0, stat_updates}, m_upd);
      chk("stat_mispred", {16'd0, stat_mispred}, m_mis);
    end
  end

  task automatic set_upd(logic v, logic [31:0] pc, logic t, logic [31:0] tg,
                         logic pt, logic [31:0] ptg);
    upd_valid       = v;
    upd_pc          = pc;
    upd_taken       = t;
    upd_target      = tg;
    upd_pred_taken  = pt;
    upd_pred_target = ptg;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    fetch_pc = 32'h0040_0010;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    step();
    chk_en = 1'b1;
    rst    = 1'b0;

    // Reset state
    chk("rst pred_taken",  {31'd0, pred_taken}, 32'd0);
    chk("rst pred_target", pred_target, 32'h0);
    chk("rst stat_upd",    {16'd0, stat_updates}, 32'd0);
    chk("rst stat_mis",    {16'd0, stat_mispred}, 32'd0);
    chk("rst mispredict",  {31'd0, mispredict}, 32'd0);

    // First taken branch allocates and mispredicts
    set_upd(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("alloc mispredict",  {31'd0, mispredict}, 32'd1);
    chk("alloc stat_mis",    {16'd0, stat_mispred}, 32'd1);
    chk("alloc stat_upd",    {16'd0, stat_updates}, 32'd1);
    chk("alloc pred_taken",  {31'd0, pred_taken}, 32'd1);
    chk("alloc pred_target", pred_target, 32'h0040_0100);
    step();
    chk("pulse one cycle",   {31'd0, mispredict}, 32'd0);

    // Saturation: three taken hits (10 -> 11), then two not-taken
    repeat (3) begin
      set_upd(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
      step();
    end
    chk("sat no mispredict", {31'd0, mispredict}, 32'd0);
    set_upd(1'b1, 32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
    step();
    chk("sat nt1 taken",     {31'd0, pred_taken}, 32'd1);
    chk("sat nt1 misp",      {31'd0, mispredict}, 32'd1);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("sat nt2 taken",     {31'd0, pred_taken}, 32'd0);
    chk("sat nt2 target",    pred_target, 32'h0);
    chk("sat nt2 misp held", {31'd0, mispredict}, 32'd1);
    chk("sat stat_upd",      {16'd0, stat_updates}, 32'd6);

    // Aliasing: 0x00400050 shares the slot of 0x00400010
    set_upd(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
    step();
    set_upd(1'b1, 32'h0040_0050, 1'b1, 32'h0040_0300, 1'b0, 32'h0);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("alias old evicted", {31'd0, pred_taken}, 32'd0);
    fetch_pc = 32'h0040_0050;
    #1;
    chk("alias new hit",     {31'd0, pred_taken}, 32'd1);
    chk("alias new target",  pred_target, 32'h0040_0300);

    // Same-cycle lookup and update: read-before-write
    do_reset();
    fetch_pc = 32'h0040_0010;
    set_upd(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    #1;
    chk("rbw same cycle",    {31'd0, pred_taken}, 32'd0);
    step();
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rbw next cycle",    {31'd0, pred_taken}, 32'd1);

    // Randomized traffic over a small PC pool to get hits and aliases
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc_u;
      logic [31:0] tg;
      rst  = ($urandom_range(0, 299) == 0);
      pc_u = 32'h0040_0000 + ($urandom_range(0, 3) << 6) +
             ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      tg   = 32'h0041_0000 + ($urandom_range(0, 7) << 2);
      fetch_pc = 32'h0040_0000 + ($urandom_range(0, 3) << 6) +
                 ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      set_upd(1'($urandom_range(0, 1)), pc_u, 1'($urandom_range(0, 1)), tg,
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? tg : 32'h0041_0000 + ($urandom_range(0, 7) << 2));
      step();
    end
    rst = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Counter wrap
    do_reset();
    set_upd(1'b1, 32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (65535) step();
    chk("wrap at ffff",      {16'd0, stat_updates}, 32'h0000_FFFF);
    step();
    chk("wrap to 0",         {16'd0, stat_updates}, 32'd0);
    chk("wrap no mispred",   {16'd0, stat_mispred}, 32'd0);

    // Reset beats a mispredicting taken update in the same cycle
    set_upd(1'b1, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
    step();
    fetch_pc = 32'h0040_0010;
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("rstprio stat_upd",  {16'd0, stat_updates}, 32'd0);
    chk("rstprio stat_mis",  {16'd0, stat_mispred}, 32'd0);
    chk("rstprio misp",      {31'd0, mispredict}, 32'd0);
    chk("rstprio pred",      {31'd0, pred_taken}, 32'd0);
    chk("rstprio target",    pred_target, 32'h0);
    step();
    chk("rstprio no alloc",  {31'd0, pred_taken}, 32'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
